// File: rtl/i2s_unit_if.sv
// i2s_unit_if
//   Groups the sample-request and I2S output signals of i2s_unit.
//   play_in    : play enable, synchronous to mclk
//   audio0_in  : left sample (24 bit, two's complement)
//   audio1_in  : right sample (24 bit, two's complement)
//   req_out    : one-cycle request for the next sample pair
//   sck_out    : I2S serial clock
//   ws_out     : word select (0 = left, 1 = right)
//   sdo_out    : serial data, MSB first
//   modport master : the I2S serializer (drives the I2S lines and req_out)
//   modport slave  : the sample source / environment
interface i2s_unit_if;
    logic        play_in;
    logic [23:0] audio0_in;
    logic [23:0] audio1_in;
    logic        req_out;
    logic        sck_out;
    logic        ws_out;
    logic        sdo_out;

    modport master (
        input  play_in, audio0_in, audio1_in,
        output req_out, sck_out, ws_out, sdo_out
    );

    modport slave (
        output play_in, audio0_in, audio1_in,
        input  req_out, sck_out, ws_out, sdo_out
    );
endinterface

// File: rtl/i2s_unit.sv
// i2s_unit
//   Serializes stereo 24-bit sample pairs onto an I2S link in the mclk
//   domain. One sck period is 8 mclk cycles, one frame is 48 sck periods
//   (384 mclk). A sample pair is requested with a one-cycle req_out pulse at
//   the start of each PLAY frame, captured at the end of that frame and
//   transmitted during the following frame.
//   Ports:
//     mclk   : master clock, the only clock
//     mrst_n : asynchronous active-low reset
//     bus    : i2s_unit_if.master (play/audio inputs, req/sck/ws/sdo outputs)
module i2s_unit (
    input  logic          mclk,
    input  logic          mrst_n,
    i2s_unit_if.master    bus
);
    localparam int          MCLK_DIV_48000 = 8;
    localparam int          SLOTS          = 48;
    localparam int          FRAME_LEN      = MCLK_DIV_48000 * SLOTS;
    localparam logic [8:0]  CTR_LAST       = 9'(FRAME_LEN - 1);
    localparam logic [8:0]  LOAD_CTR       = 9'(MCLK_DIV_48000);       // start of slot 1
    localparam logic [8:0]  WS_START       = 9'(24 * MCLK_DIV_48000);  // start of slot 24
    localparam logic [8:0]  DRAIN_LAST     = 9'(MCLK_DIV_48000 - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        STOPPING = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t       state_reg;
    logic [8:0]   ctr_reg;
    logic [47:0]  hold_reg;
    logic [47:0]  shift_reg;
    logic         req_reg;
    logic         ws_reg;

    logic         ctr_wrap;
    logic [8:0]   ctr_adv;

    assign ctr_wrap = (ctr_reg == CTR_LAST);
    assign ctr_adv  = ctr_wrap ? 9'd0 : ctr_reg + 9'd1;

    // All outputs are flop outputs; the ws/req flops are computed from the
    // counter value they will accompany, so they line up with ctr_reg.
    assign bus.req_out = req_reg;
    assign bus.sck_out = ctr_reg[2];
    assign bus.ws_out  = ws_reg;
    assign bus.sdo_out = shift_reg[47];

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_reg <= IDLE;
            ctr_reg   <= '0;
            hold_reg  <= '0;
            shift_reg <= '0;
            req_reg   <= 1'b0;
            ws_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    ctr_reg   <= '0;
                    hold_reg  <= '0;
                    shift_reg <= '0;
                    ws_reg    <= 1'b0;
                    // The first PLAY cycle is ctr = 0, which carries the request.
                    req_reg   <= bus.play_in;
                    if (bus.play_in)
                        state_reg <= PLAY;
                end

                PLAY, STOPPING: begin
                    ctr_reg <= ctr_adv;
                    ws_reg  <= (ctr_adv >= WS_START);
                    req_reg <= (state_reg == PLAY) && bus.play_in && ctr_wrap;

                    // Capture happens only while still playing, so a stopping
                    // frame never picks up a pair that will not be sent.
                    if (state_reg == PLAY && ctr_wrap)
                        hold_reg <= {bus.audio0_in, bus.audio1_in};

                    // Load at slot 1, shift at every other slot start
                    // (including slot 0 of the next frame, which emits the
                    // right-channel LSB).
                    if (ctr_adv == LOAD_CTR)
                        shift_reg <= hold_reg;
                    else if (ctr_adv[2:0] == 3'd0)
                        shift_reg <= {shift_reg[46:0], 1'b0};

                    if (state_reg == PLAY) begin
                        if (!bus.play_in)
                            state_reg <= STOPPING;
                    end else if (ctr_wrap) begin
                        state_reg <= DRAIN;
                    end
                end

                DRAIN: begin
                    // One slot-0 period so the right LSB gets its full sck period.
                    ws_reg  <= 1'b0;
                    req_reg <= 1'b0;
                    if (ctr_reg == DRAIN_LAST) begin
                        state_reg <= IDLE;
                        ctr_reg   <= '0;
                        shift_reg <= '0;
                    end else begin
                        ctr_reg <= ctr_reg + 9'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    ctr_reg   <= '0;
                    shift_reg <= '0;
                    req_reg   <= 1'b0;
                    ws_reg    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_unit.sv
`timescale 1ns/1ps
module tb_i2s_unit;
    logic mclk   = 1'b0;
    logic mrst_n = 1'b0;

    i2s_unit_if bus ();

    i2s_unit dut (
        .mclk   (mclk),
        .mrst_n (mrst_n),
        .bus    (bus)
    );

    always #5 mclk = ~mclk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    always @(posedge mclk) cyc <= cyc + 1;

    // Expected 48-bit words ({left, right}) in transmission order.
    logic [47:0] exp_q[$];
    logic [47:0] last_word = '0;
    longint      last_req  = -1;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.req_out, bus.sck_out, bus.ws_out, bus.sdo_out};
    endfunction

    // ------------------------------------------------------------------
    // Monitor: reconstructs slots from sck rising edges (the receiver's
    // sampling point), checks ws per slot and assembles each word from
    // slots 1..47 plus the following slot 0.
    // ------------------------------------------------------------------
    int          ri        = 0;
    int          nb        = 0;
    int          mon_words = 0;
    logic [47:0] acc       = '0;
    logic        prev_sck  = 1'b0;

    always @(negedge mclk) begin
        if (!mrst_n) begin
            ri       = 0;
            nb       = 0;
            prev_sck = 1'b0;
        end else begin
            if (bus.req_out) ri = 0;
            if (bus.sck_out && !prev_sck) begin
                int s;
                s = ri % 48;
                check("ws_per_slot", 48'(bus.ws_out), 48'(s >= 24));
                if (s == 1) begin
                    acc = {47'd0, bus.sdo_out};
                    nb  = 1;
                end else if (s >= 2 && nb == s - 1) begin
                    acc = {acc[46:0], bus.sdo_out};
                    nb++;
                end else if (s == 0 && nb == 47) begin
                    acc = {acc[46:0], bus.sdo_out};
                    nb  = 0;
                    if (exp_q.size() == 0) begin
                        check("scoreboard_underflow", 48'd1, 48'd0);
                    end else begin
                        logic [47:0] e;
                        e = exp_q.pop_front();
                        $display("word %0d: got %h expected %h", mon_words, acc, e);
                        mon_words++;
                        check("serial_word", acc, e);
                    end
                end
                ri++;
            end
            prev_sck = bus.sck_out;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge mclk);
    endtask

    // Raise play; the next cycle must be the first PLAY cycle (ctr = 0).
    // The first frame of every run carries zeros.
    task automatic start_play();
        bus.play_in = 1'b1;
        exp_q.push_back(48'd0);
        last_word = 48'd0;
        last_req  = -1;
        step();
    endtask

    // Called at the ctr = 0 cycle of a frame. cut_kind: 0 none, 1 drop
    // play_in at ctr = cut_at, 2 assert reset at ctr = cut_at.
    task automatic run_frame(input logic [23:0] a0, input logic [23:0] a1,
                             input int cut_kind, input int cut_at);
        int   rises = 0;
        int   extra = 0;
        logic psck;
        check("req_pulse", 48'(bus.req_out), 48'd1);
        if (last_req >= 0)
            check("req_spacing", 48'(cyc - last_req), 48'd384);
        last_req = cyc;
        bus.audio0_in = a0;
        bus.audio1_in = a1;
        // A pair is transmitted only if play is still high when the frame ends.
        if (cut_kind == 0) begin
            exp_q.push_back({a0, a1});
            last_word = {a0, a1};
        end
        psck = bus.sck_out;
        for (int k = 1; k < 384; k++) begin
            step();
            if (bus.sck_out && !psck) rises++;
            psck = bus.sck_out;
            if (bus.req_out) extra++;
            if (k == cut_at) begin
                if (cut_kind == 1) begin
                    bus.play_in = 1'b0;
                end else if (cut_kind == 2) begin
                    mrst_n = 1'b0;
                    #1;
                    check("async_reset_outputs", 48'(outs()), 48'd0);
                    exp_q.delete();
                    return;
                end
            end
        end
        check("sck_rises_per_frame", 48'(rises), 48'd48);
        check("no_req_mid_frame", 48'(extra), 48'd0);
        step();
    endtask

    // Called at the first DRAIN cycle; ends at the first IDLE cycle.
    task automatic drain(input bit reraise);
        logic [3:0] e;
        for (int i = 0; i < 8; i++) begin
            e = {1'b0, logic'(i >= 4), 1'b0, last_word[0]};
            check("drain_outputs", 48'(outs()), 48'(e));
            if (reraise && i == 3) bus.play_in = 1'b1;
            step();
        end
        check("idle_after_drain", 48'(outs()), 48'd0);
    endtask

    initial begin
        int          bad;
        logic [23:0] base;

        bus.play_in   = 1'b0;
        bus.audio0_in = '0;
        bus.audio1_in = '0;
        mrst_n        = 1'b0;
        repeat (3) step();
        check("reset_outputs", 48'(outs()), 48'd0);
        mrst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (outs() != 4'd0) bad++;
        end
        check("idle_quiet", 48'(bad), 48'd0);

        // Constant pattern, then ten frames of incrementing data, then stop at ctr = 100.
        start_play();
        run_frame(24'hABCDEF, 24'h123456, 0, 0);
        run_frame(24'hABCDEF, 24'h123456, 0, 0);
        base = 24'($urandom);
        for (int f = 0; f < 10; f++)
            run_frame(base + 24'(2 * f), base + 24'(2 * f + 1), 0, 0);
        run_frame(24'($urandom), 24'($urandom), 1, 100);
        drain(1'b0);

        // Reset mid-word at ctr = 200.
        start_play();
        run_frame(24'($urandom), 24'($urandom), 0, 0);
        run_frame(24'($urandom), 24'($urandom), 2, 200);
        bus.play_in = 1'b0;
        repeat (4) step();
        mrst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (outs() != 4'd0) bad++;
        end
        check("idle_after_reset", 48'(bad), 48'd0);

        // Stop at a random point, re-raise play during DRAIN.
        start_play();
        run_frame(24'($urandom), 24'($urandom), 0, 0);
        run_frame(24'($urandom), 24'($urandom), 1, int'($urandom_range(1, 382)));
        drain(1'b1);
        start_play();
        run_frame(24'($urandom), 24'($urandom), 0, 0);
        run_frame(24'($urandom), 24'($urandom), 0, 0);
        run_frame(24'($urandom), 24'($urandom), 1, 100);
        drain(1'b0);

        repeat (20) step();
        check("scoreboard_empty", 48'(exp_q.size()), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
